fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage sitting next to the program counter. Owns the fetch pointer and
//  issues word reads to instruction memory over a req/ack handshake. Buffers returned words
//  with their addresses in a small queue, and hands them to decode over valid/ready.
//  Jumps arrive as a redirect with the same semantics as the counter's load (st + target).
// PARAMETERS
//  ADDR_W  16  fetch address width; pointer wraps modulo 2**ADDR_W
//  DATA_W  16  instruction word width
//  DEPTH   2   instruction queue entries, power of two, >= 2
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  redir        in   1       jump taken: flush and reload fetch pointer
//  redir_addr   in   ADDR_W  jump target
//  mem_req      out  1       read request to instruction memory
//  mem_addr     out  ADDR_W  read address, held stable while mem_req=1
//  mem_ack      in   1       read data valid; completes the request this cycle
//  mem_rdata    in   DATA_W  read data, sampled when mem_ack=1
//  out_valid    out  1       queue head is valid
//  out_instr    out  DATA_W  instruction at queue head
//  out_pc       out  ADDR_W  address of out_instr
//  out_ready    in   1       decode accepts head when out_valid & out_ready
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - fetch_ptr=0, queue empty, state IDLE
//   - mem_req=0, out_valid=0, mem_addr=0, out_instr=0, out_pc=0
//  FSM, state register in flops:
//   - IDLE: raise mem_req with mem_addr=fetch_ptr when credit ok; go to WAIT.
//   - WAIT: hold req/addr until mem_ack. On ack, push {fetch_ptr, mem_rdata}, fetch_ptr+=1
//     (wraps FFFF->0), return to IDLE; mem_req=0 for at least 1 cycle.
//   - DROP: request outstanding whose data is stale. Hold req/addr until ack, discard data,
//     go to IDLE. fetch_ptr is not incremented.
//  Credit: issue only if count - pop + 0 < DEPTH, i.e. a slot is guaranteed for the data.
//   At most one request outstanding. Pop in the same cycle frees its slot.
//  mem_ack with mem_req=0 is ignored. Ack may come in the same cycle req rises:
//   min fetch latency is req->ack 1 cycle, data at out_valid next edge.
//  Redirect (single-cycle pulse, may repeat):
//   - queue flushed: out_valid=0 next cycle; fetch_ptr<=redir_addr.
//   - WAIT -> DROP; DROP stays DROP; IDLE -> IDLE. A request is never withdrawn.
//   - redir with mem_ack same cycle: response discarded, state IDLE, ptr=redir_addr.
//   - redir with pop same cycle: redir wins; the pop is treated as not happening.
//  Queue:
//   - push and pop in the same cycle is legal when full or empty (empty: no bypass, data
//     appears next cycle).
//   - out_* come straight from the head entry; hold steady while out_valid & !out_ready.
// STRUCTURE
//  cpu_pkg: WORD_W=16, ADDR_W=16 constants; fetch_state_e {IDLE,WAIT,DROP};
//   fetch_entry_t struct {pc, instr}.
//  Sub-module fetch_fifo (DEPTH entries of fetch_entry_t):
//   - push/pop/flush, count, full, empty; flush has priority over push.
//  Top holds the FSM, fetch_ptr and credit logic.
// TESTING
//  1. Reset, then mem_ack tied to 1-cycle latency, out_ready=1:
//     out_pc 0,1,2,3 with matching rdata; mem_addr 0,1,2,...
//  2. out_ready=0 with DEPTH=2: exactly 2 requests complete, mem_req stays 0;
//     raising ready resumes at addr 2.
//  3. redir to 0x0040 during WAIT on addr 5, ack 3 cycles later:
//     word 5 discarded; next req addr 0x0040; first out_pc=0x0040.
//  4. redir and mem_ack same cycle, and redir with pop:
//     no stale entry emerges; queue empty next cycle.
//  5. fetch_ptr=0xFFFF fetch: next mem_addr=0x0000.
//  6. rst_n asserted mid-WAIT: mem_req, out_valid drop immediately (async);
//     restart fetches addr 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and widths for the instruction fetch path.
package cpu_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        fetch_state_e state;
        logic         q_full;
    } fetch_dbg_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between fetch, instruction memory and decode.
// Handshakes: mem_req/mem_addr hold until mem_ack (ack may land in the first req cycle);
// out_valid/out_instr/out_pc hold until out_ready, transfer when out_valid & out_ready.
interface fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              redir;
    logic [ADDR_W-1:0] redir_addr;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              out_ready;

    modport master (
        input  redir, redir_addr, mem_ack, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_instr, out_pc
    );

    modport slave (
        output redir, redir_addr, mem_ack, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small circular queue of fetched {pc, instr} entries; flush beats push and pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full queue may still take a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch pointer, issues one memory read at a time when a queue
// slot is guaranteed, and discards responses made stale by a redirect.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::WORD_W,
    parameter int DEPTH  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus,
    output fetch_dbg_t   dbg
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              push, pop, credit_ok;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    fetch_entry_t      push_entry, head;

    // A redirect cancels any pop seen in the same cycle.
    assign pop        = ~fifo_empty & bus.out_ready & ~bus.redir;
    assign credit_ok  = (fifo_count - CNT_W'(pop)) < CNT_W'(DEPTH);
    assign push_entry = '{pc: addr_q, instr: bus.mem_rdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_ptr_q <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            fetch_ptr_q <= fetch_ptr_d;
            addr_q      <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_ptr_d = fetch_ptr_q;
        addr_d      = addr_q;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.redir && credit_ok) begin
                    state_d = WAIT;
                    addr_d  = fetch_ptr_q;
                end
            end
            WAIT: begin
                if (bus.mem_ack) begin
                    state_d = IDLE;
                    if (!bus.redir) begin
                        push        = 1'b1;
                        fetch_ptr_d = fetch_ptr_q + ADDR_W'(1);
                    end
                end else if (bus.redir) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // The outstanding request is never withdrawn; only the pointer moves.
        if (bus.redir) fetch_ptr_d = bus.redir_addr;
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redir),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.mem_req   = (state_q != IDLE);
    assign bus.mem_addr  = addr_q;
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;
    assign dbg           = '{state: state_q, q_full: fifo_full};

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, decode driver, transaction-level model.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    fetch_dbg_t dbg;

    fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    fetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .dbg   (dbg)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int lat_mode = 0;  // 0..3 fixed ack latency, 4 random latency plus stray acks

    // Model: instructions decode must see, in order, as {pc, instr}
    logic [31:0] exp_q[$];
    logic [15:0] acc_pc_q[$], acc_instr_q[$], req_addr_q[$];
    logic [15:0] exp_fetch, addr_prev, pc_prev, instr_prev;
    logic        stale, req_cont, ack_prev, hold_prev, redir_prev;

    function automatic logic [15:0] word_of(logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory responder
    logic in_req = 1'b0;
    int   waited = 0;
    int   cur_lat = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            in_req      = 1'b0;
            bus.mem_ack = 1'b0;
        end else if (bus.mem_req) begin
            if (!in_req) begin
                in_req  = 1'b1;
                waited  = 0;
                cur_lat = (lat_mode == 4) ? int'($urandom_range(0, 3)) : lat_mode;
            end
            if (waited == cur_lat) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = word_of(bus.mem_addr);
                in_req        = 1'b0;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 16'($urandom);
                waited++;
            end
        end else begin
            in_req        = 1'b0;
            bus.mem_ack   = (lat_mode == 4) && ($urandom_range(0, 3) == 0);
            bus.mem_rdata = 16'($urandom);
        end
    end

    // Compare process: check outputs against the model, then advance the model
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            exp_q.delete();
            exp_fetch  = 16'h0000;
            stale      = 1'b0;
            req_cont   = 1'b0;
            ack_prev   = 1'b0;
            hold_prev  = 1'b0;
            redir_prev = 1'b0;
        end else begin
            if (redir_prev) chk("flush_valid", 32'(bus.out_valid), 32'd0);
            if (hold_prev) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_pc", 32'(bus.out_pc), 32'(pc_prev));
                chk("hold_instr", 32'(bus.out_instr), 32'(instr_prev));
            end
            chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            if (bus.out_valid && exp_q.size() != 0) begin
                chk("head_pc", 32'(bus.out_pc), 32'(exp_q[0][31:16]));
                chk("head_instr", 32'(bus.out_instr), 32'(exp_q[0][15:0]));
            end
            if (ack_prev) chk("req_gap", 32'(bus.mem_req), 32'd0);
            if (bus.mem_req) begin
                if (req_cont) begin
                    chk("addr_hold", 32'(bus.mem_addr), 32'(addr_prev));
                end else begin
                    chk("req_addr", 32'(bus.mem_addr), 32'(exp_fetch));
                    chk("credit", 32'(exp_q.size() < DEPTH), 32'd1);
                    req_addr_q.push_back(bus.mem_addr);
                end
            end
            if (bus.out_valid && bus.out_ready && !bus.redir && exp_q.size() != 0) begin
                acc_pc_q.push_back(bus.out_pc);
                acc_instr_q.push_back(bus.out_instr);
                void'(exp_q.pop_front());
            end
            if (bus.mem_req && bus.mem_ack) begin
                if (!stale && !bus.redir) begin
                    exp_q.push_back({exp_fetch, word_of(exp_fetch)});
                    exp_fetch = exp_fetch + 16'd1;
                end
                stale = 1'b0;
            end else if (bus.mem_req && bus.redir) begin
                stale = 1'b1;
            end
            if (bus.redir) begin
                exp_q.delete();
                exp_fetch = bus.redir_addr;
            end
            hold_prev  = bus.out_valid & ~bus.out_ready & ~bus.redir;
            pc_prev    = bus.out_pc;
            instr_prev = bus.out_instr;
            req_cont   = bus.mem_req & ~bus.mem_ack;
            ack_prev   = bus.mem_req & bus.mem_ack;
            addr_prev  = bus.mem_addr;
            redir_prev = bus.redir;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.redir = 1'b0;
        repeat (3) @(posedge clk);
        acc_pc_q.delete();
        acc_instr_q.delete();
        req_addr_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_acc(int n, string tag);
        for (int i = 0; i < 400 && acc_pc_q.size() < n; i++) @(posedge clk);
        #2;
        chk(tag, 32'(acc_pc_q.size() >= n), 32'd1);
    endtask

    task automatic wait_req(int n, string tag);
        for (int i = 0; i < 400 && req_addr_q.size() < n; i++) @(posedge clk);
        #2;
        chk(tag, 32'(req_addr_q.size() >= n), 32'd1);
    endtask

    initial begin
        logic [15:0] t1_instr [4];
        int n_acc, n_req;
        logic found;
        t1_instr = '{16'hC3A5, 16'hC3A4, 16'hC3A7, 16'hC3A6};
        bus.redir = 1'b0;
        bus.redir_addr = 16'h0000;
        bus.out_ready = 1'b1;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 16'h0000;

        // 1: reset values, then streaming with ack in the first req cycle
        lat_mode = 0;
        @(posedge clk);
        #2;
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_instr", 32'(bus.out_instr), 32'd0);
        chk("rst_pc", 32'(bus.out_pc), 32'd0);
        chk("rst_state", 32'(dbg.state), 32'(IDLE));
        do_reset();
        wait_acc(4, "t1_wait");
        for (int i = 0; i < 4 && i < acc_pc_q.size(); i++) begin
            chk("t1_pc", 32'(acc_pc_q[i]), 32'(i));
            chk("t1_instr", 32'(acc_instr_q[i]), 32'(t1_instr[i]));
            chk("t1_req", 32'(req_addr_q[i]), 32'(i));
        end

        // 2: decode stalled, only DEPTH requests complete
        bus.out_ready = 1'b0;
        do_reset();
        repeat (20) @(posedge clk);
        #2;
        chk("t2_req_count", 32'(req_addr_q.size()), 32'd2);
        chk("t2_req_low", 32'(bus.mem_req), 32'd0);
        chk("t2_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_pc", 32'(bus.out_pc), 32'd0);
        bus.out_ready = 1'b1;
        wait_req(3, "t2_wait");
        if (req_addr_q.size() >= 3) chk("t2_resume", 32'(req_addr_q[2]), 32'd2);

        // 3: redirect while waiting on addr 5, ack arrives 3 cycles later
        lat_mode = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #2;
            found = bus.mem_req && (bus.mem_addr == 16'd5) && !bus.mem_ack;
        end
        chk("t3_found", 32'(found), 32'd1);
        n_acc = acc_pc_q.size();
        n_req = req_addr_q.size();
        bus.redir = 1'b1;
        bus.redir_addr = 16'h0040;
        @(posedge clk);
        #2;
        bus.redir = 1'b0;
        chk("t3_state", 32'(dbg.state), 32'(DROP));
        chk("t3_req_held", 32'(bus.mem_req), 32'd1);
        chk("t3_acc_before", 32'(n_acc), 32'd5);
        wait_req(n_req + 2, "t3_wait_req");
        wait_acc(n_acc + 1, "t3_wait_acc");
        if (req_addr_q.size() >= n_req + 2) begin
            chk("t3_req5", 32'(req_addr_q[n_req]), 32'h5);
            chk("t3_req_tgt", 32'(req_addr_q[n_req + 1]), 32'h40);
        end
        if (acc_pc_q.size() >= n_acc + 1) begin
            chk("t3_pc_tgt", 32'(acc_pc_q[n_acc]), 32'h40);
            chk("t3_instr_tgt", 32'(acc_instr_q[n_acc]), 32'hC3E5);
        end

        // 4a: redirect in the same cycle as mem_ack
        lat_mode = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #2;
            found = bus.mem_req && bus.mem_ack;
        end
        chk("t4a_found", 32'(found), 32'd1);
        n_acc = acc_pc_q.size();
        bus.redir = 1'b1;
        bus.redir_addr = 16'h0100;
        @(posedge clk);
        #2;
        bus.redir = 1'b0;
        chk("t4a_valid", 32'(bus.out_valid), 32'd0);
        chk("t4a_state", 32'(dbg.state), 32'(IDLE));
        wait_acc(n_acc + 1, "t4a_wait");
        if (acc_pc_q.size() >= n_acc + 1) chk("t4a_pc", 32'(acc_pc_q[n_acc]), 32'h100);

        // 4b: redirect in the same cycle as a pop
        lat_mode = 0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #2;
            found = bus.out_valid;
        end
        chk("t4b_found", 32'(found), 32'd1);
        n_acc = acc_pc_q.size();
        bus.redir = 1'b1;
        bus.redir_addr = 16'h0200;
        @(posedge clk);
        #2;
        bus.redir = 1'b0;
        chk("t4b_valid", 32'(bus.out_valid), 32'd0);
        wait_acc(n_acc + 1, "t4b_wait");
        if (acc_pc_q.size() >= n_acc + 1) chk("t4b_pc", 32'(acc_pc_q[n_acc]), 32'h200);

        // 5: pointer wrap from 0xFFFF
        do_reset();
        bus.redir = 1'b1;
        bus.redir_addr = 16'hFFFF;
        @(posedge clk);
        #2;
        bus.redir = 1'b0;
        wait_req(2, "t5_wait_req");
        wait_acc(2, "t5_wait_acc");
        if (req_addr_q.size() >= 2) begin
            chk("t5_req0", 32'(req_addr_q[0]), 32'hFFFF);
            chk("t5_req1", 32'(req_addr_q[1]), 32'h0000);
        end
        if (acc_pc_q.size() >= 2) begin
            chk("t5_pc0", 32'(acc_pc_q[0]), 32'hFFFF);
            chk("t5_instr0", 32'(acc_instr_q[0]), 32'h3C5A);
            chk("t5_pc1", 32'(acc_pc_q[1]), 32'h0000);
        end

        // 6: asynchronous reset in the middle of a WAIT
        lat_mode = 3;
        bus.out_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #2;
            found = bus.mem_req && bus.out_valid;
        end
        chk("t6_found", 32'(found), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_req", 32'(bus.mem_req), 32'd0);
        chk("t6_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_addr", 32'(bus.mem_addr), 32'd0);
        chk("t6_state", 32'(dbg.state), 32'(IDLE));
        bus.out_ready = 1'b1;
        do_reset();
        wait_req(1, "t6_wait");
        if (req_addr_q.size() >= 1) chk("t6_restart", 32'(req_addr_q[0]), 32'd0);

        // 7: random latency, stray acks, decode stalls and redirects
        lat_mode = 4;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.redir = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0)
                bus.redir_addr = 16'($urandom_range(16'hFFFC, 16'hFFFF));
            else
                bus.redir_addr = 16'($urandom);
        end
        bus.redir = 1'b0;
        chk("t7_progress", 32'(acc_pc_q.size() > 200), 32'd1);
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
